// File: rtl/dbus_pkg.sv
// Shared types and constants for the CPU data-bus bridge.
// Optional display register (macro DBUS_SEG_EN) lives at SEG_ADDR.
package dbus_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = 4;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;

    localparam logic [31:0] SEG_ADDR = 32'h1003_0000;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    // Attributes of the in-flight access needed to shape the load result.
    typedef struct packed {
        logic [1:0] size;
        logic       sign;
        logic [1:0] lane;
    } xfer_t;

endpackage

// File: rtl/dbus_if.sv
// CPU-side and slave-side bus bundles of the data-bus bridge.
interface dbus_cpu_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              cpu_rd;
    logic              cpu_wr;
    logic [1:0]        cpu_size;
    logic              cpu_sign;
    logic [ADDR_W-1:0] cpu_addr;
    logic [31:0]       cpu_wdata;
    logic [31:0]       cpu_rdata;
    logic              cpu_ready;
    logic              cpu_err;

    modport master (output cpu_rd, cpu_wr, cpu_size, cpu_sign, cpu_addr, cpu_wdata,
                    input  cpu_rdata, cpu_ready, cpu_err);
    modport slave  (input  cpu_rd, cpu_wr, cpu_size, cpu_sign, cpu_addr, cpu_wdata,
                    output cpu_rdata, cpu_ready, cpu_err);
endinterface

interface dbus_slv_if #(
    parameter int unsigned N_SLV     = 2,
    parameter int unsigned REGION_AW = 16
);
    logic [N_SLV-1:0]    slv_req;
    logic                slv_we;
    logic [REGION_AW-1:0] slv_addr;
    logic [31:0]         slv_wdata;
    logic [3:0]          slv_be;
    logic [N_SLV*32-1:0] slv_rdata;
    logic [N_SLV-1:0]    slv_ack;

    modport master (output slv_req, slv_we, slv_addr, slv_wdata, slv_be,
                    input  slv_rdata, slv_ack);
    modport slave  (input  slv_req, slv_we, slv_addr, slv_wdata, slv_be,
                    output slv_rdata, slv_ack);
endinterface

// File: rtl/dbus_lane.sv
// Little-endian byte-lane logic: store steering/byte enables and load extraction/extension.
module dbus_lane
    import dbus_pkg::*;
(
    input  logic [1:0]  i_st_size,
    input  logic [1:0]  i_st_lane,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_ld_size,
    input  logic        i_ld_sign,
    input  logic [1:0]  i_ld_lane,
    input  logic [31:0] i_rword,
    output logic [31:0] o_wdata_c,
    output logic [3:0]  o_be_c,
    output logic [31:0] o_rdata_c
);
    logic [31:0] w_shifted;

    always_comb begin
        o_be_c    = 4'h0;
        o_wdata_c = 32'h0;
        case (i_st_size)
            SZ_WORD: begin
                o_be_c    = 4'hF;
                o_wdata_c = i_wdata;
            end
            SZ_HALF: begin
                o_be_c    = 4'b0011 << {i_st_lane[1], 1'b0};
                o_wdata_c = {16'h0, i_wdata[15:0]} << {i_st_lane[1], 4'b0000};
            end
            default: begin
                o_be_c    = 4'b0001 << i_st_lane;
                o_wdata_c = {24'h0, i_wdata[7:0]} << {i_st_lane, 3'b000};
            end
        endcase
    end

    assign w_shifted = i_rword >> {i_ld_lane, 3'b000};

    always_comb begin
        o_rdata_c = i_rword;
        case (i_ld_size)
            SZ_HALF: o_rdata_c = {{16{i_ld_sign & w_shifted[15]}}, w_shifted[15:0]};
            SZ_BYTE: o_rdata_c = {{24{i_ld_sign & w_shifted[7]}}, w_shifted[7:0]};
            default: o_rdata_c = i_rword;
        endcase
    end

endmodule

// File: rtl/dbus_bridge.sv
// Load/store bridge from the CPU data port to N_SLV memory-mapped slaves with wait states and timeout.
// Define DBUS_SEG_EN to add the word-only display register at SEG_ADDR and the seg_val output.
module dbus_bridge
    import dbus_pkg::*;
#(
    parameter int unsigned             N_SLV       = 2,
    parameter int unsigned             ADDR_W      = 32,
    parameter int unsigned             REGION_AW   = 16,
    parameter logic [N_SLV*ADDR_W-1:0] REGION_BASE = {32'h1002_0000, 32'h1001_0000},
    parameter int unsigned             TIMEOUT     = 15
) (
    input logic        clk,
    input logic        rst,
    dbus_cpu_if.slave  cpu,
    dbus_slv_if.master slv
`ifdef DBUS_SEG_EN
    ,
    output logic [31:0] seg_val
`endif
);
    localparam int unsigned UP_W  = ADDR_W - REGION_AW;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_t               r_state, w_state_nxt;
    logic [N_SLV-1:0]     r_req, w_req_nxt;
    logic                 r_we, w_we_nxt;
    logic [REGION_AW-1:0] r_addr, w_addr_nxt;
    logic [31:0]          r_wdata, w_wdata_nxt;
    logic [3:0]           r_be, w_be_nxt;
    logic                 r_ready, w_ready_nxt;
    logic                 r_err, w_err_nxt;
    logic [31:0]          r_rdata, w_rdata_nxt;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt;
    xfer_t                r_xfer, w_xfer_nxt;
`ifdef DBUS_SEG_EN
    logic [31:0]          r_seg, w_seg_nxt;
    logic                 w_seg_hit;
`endif

    logic             w_hit, w_bad, w_ack;
    logic [N_SLV-1:0] w_sel;
    logic [31:0]      w_rword, w_st_wdata, w_ld_data;
    logic [3:0]       w_st_be;

    // Region decode; iterating downwards lets the lowest index win on overlap.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = N_SLV - 1; i >= 0; i--) begin
            if (cpu.cpu_addr[ADDR_W-1:REGION_AW] == REGION_BASE[i*ADDR_W+REGION_AW +: UP_W]) begin
                w_hit = 1'b1;
                w_sel = N_SLV'(1) << i;
            end
        end
    end

    assign w_bad = (cpu.cpu_size == SZ_HALF && cpu.cpu_addr[0])
                 || (cpu.cpu_size == SZ_WORD && cpu.cpu_addr[1:0] != 2'b00)
                 || (cpu.cpu_size == 2'b11)
                 || (cpu.cpu_rd && cpu.cpu_wr);

`ifdef DBUS_SEG_EN
    assign w_seg_hit = (cpu.cpu_addr == ADDR_W'(SEG_ADDR));
`endif

    // Read data and ack of the selected slave only.
    always_comb begin
        w_rword = 32'h0;
        w_ack   = 1'b0;
        for (int i = 0; i < N_SLV; i++) begin
            if (r_req[i]) begin
                w_rword = slv.slv_rdata[i*32 +: 32];
                w_ack   = slv.slv_ack[i];
            end
        end
    end

    dbus_lane u_lane (
        .i_st_size (cpu.cpu_size),
        .i_st_lane (cpu.cpu_addr[1:0]),
        .i_wdata   (cpu.cpu_wdata),
        .i_ld_size (r_xfer.size),
        .i_ld_sign (r_xfer.sign),
        .i_ld_lane (r_xfer.lane),
        .i_rword   (w_rword),
        .o_wdata_c (w_st_wdata),
        .o_be_c    (w_st_be),
        .o_rdata_c (w_ld_data)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_req_nxt   = r_req;
        w_we_nxt    = r_we;
        w_addr_nxt  = r_addr;
        w_wdata_nxt = r_wdata;
        w_be_nxt    = r_be;
        w_ready_nxt = 1'b0;
        w_err_nxt   = 1'b0;
        w_rdata_nxt = r_rdata;
        w_cnt_nxt   = r_cnt;
        w_xfer_nxt  = r_xfer;
`ifdef DBUS_SEG_EN
        w_seg_nxt   = r_seg;
`endif
        case (r_state)
            IDLE: begin
                if (cpu.cpu_rd || cpu.cpu_wr) begin
                    w_xfer_nxt.size = cpu.cpu_size;
                    w_xfer_nxt.sign = cpu.cpu_sign;
                    w_xfer_nxt.lane = cpu.cpu_addr[1:0];
`ifdef DBUS_SEG_EN
                    if (w_seg_hit) begin
                        w_state_nxt = RESP;
                        w_ready_nxt = 1'b1;
                        w_rdata_nxt = 32'h0;
                        if (cpu.cpu_size != SZ_WORD || (cpu.cpu_rd && cpu.cpu_wr)) begin
                            w_err_nxt = 1'b1;
                        end else if (cpu.cpu_wr) begin
                            w_seg_nxt = cpu.cpu_wdata;
                        end else begin
                            w_rdata_nxt = r_seg;
                        end
                    end else
`endif
                    if (!w_hit || w_bad) begin
                        w_state_nxt = RESP;
                        w_ready_nxt = 1'b1;
                        w_err_nxt   = 1'b1;
                        w_rdata_nxt = 32'h0;
                    end else begin
                        w_state_nxt = REQ;
                        w_req_nxt   = w_sel;
                        w_we_nxt    = cpu.cpu_wr;
                        w_addr_nxt  = {cpu.cpu_addr[REGION_AW-1:2], 2'b00};
                        w_be_nxt    = w_st_be;
                        w_wdata_nxt = w_st_wdata;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            REQ: begin
                if (w_ack) begin
                    w_state_nxt = RESP;
                    w_req_nxt   = '0;
                    w_ready_nxt = 1'b1;
                    w_rdata_nxt = r_we ? 32'h0 : w_ld_data;
                end else if (r_cnt == CNT_W'(TIMEOUT)) begin
                    w_state_nxt = RESP;
                    w_req_nxt   = '0;
                    w_ready_nxt = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_rdata_nxt = 32'h0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_req   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 32'h0;
            r_be    <= 4'h0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'h0;
            r_cnt   <= '0;
            r_xfer  <= '0;
`ifdef DBUS_SEG_EN
            r_seg   <= 32'h0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_req   <= w_req_nxt;
            r_we    <= w_we_nxt;
            r_addr  <= w_addr_nxt;
            r_wdata <= w_wdata_nxt;
            r_be    <= w_be_nxt;
            r_ready <= w_ready_nxt;
            r_err   <= w_err_nxt;
            r_rdata <= w_rdata_nxt;
            r_cnt   <= w_cnt_nxt;
            r_xfer  <= w_xfer_nxt;
`ifdef DBUS_SEG_EN
            r_seg   <= w_seg_nxt;
`endif
        end
    end

    assign cpu.cpu_rdata = r_rdata;
    assign cpu.cpu_ready = r_ready;
    assign cpu.cpu_err   = r_err;
    assign slv.slv_req   = r_req;
    assign slv.slv_we    = r_we;
    assign slv.slv_addr  = r_addr;
    assign slv.slv_wdata = r_wdata;
    assign slv.slv_be    = r_be;
`ifdef DBUS_SEG_EN
    assign seg_val       = r_seg;
`endif

endmodule

// File: tb/tb_dbus_bridge.sv
// Directed scoreboard bench for dbus_bridge; the DBUS_SEG_EN build adds display-register steps.
module tb_dbus_bridge;
    import dbus_pkg::*;

    localparam int unsigned N_SLV     = 2;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned REGION_AW = 16;
    localparam int unsigned TIMEOUT   = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;

    dbus_cpu_if #(.ADDR_W(ADDR_W)) cpu_bus ();
    dbus_slv_if #(.N_SLV(N_SLV), .REGION_AW(REGION_AW)) slv_bus ();
`ifdef DBUS_SEG_EN
    logic [31:0] seg_val;
`endif

    dbus_bridge #(
        .N_SLV      (N_SLV),
        .ADDR_W     (ADDR_W),
        .REGION_AW  (REGION_AW),
        .REGION_BASE({32'h1002_0000, 32'h1001_0000}),
        .TIMEOUT    (TIMEOUT)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .cpu    (cpu_bus),
        .slv    (slv_bus)
`ifdef DBUS_SEG_EN
        ,
        .seg_val(seg_val)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        bit          chk_rdata;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One CPU access against a behavioural slave that acks after dly wait cycles (-1 = never),
    // while the unselected slave acks spuriously every REQ cycle.
    task automatic access(input string tag, input logic rd, input logic wr, input logic [1:0] size,
                          input logic sign, input logic [31:0] addr, input logic [31:0] wdata,
                          input int dly, input logic [31:0] sword, input logic [1:0] ereq,
                          input logic [15:0] eaddr, input logic [3:0] ebe, input logic [31:0] ewdata,
                          input logic [31:0] erdata, input logic eerr, input int elat);
        logic [1:0]  req_seen;
        logic [31:0] mask;
        logic [31:0] obs_rdata;
        logic        obs_err;
        int          rc;
        int          lat;
        exp_t        e;
        req_seen  = 2'b00;
        rc        = 0;
        lat       = -1;
        obs_rdata = 32'h0;
        obs_err   = 1'b0;
        mask = {{8{ebe[3]}}, {8{ebe[2]}}, {8{ebe[1]}}, {8{ebe[0]}}};
        slv_bus.slv_rdata = (ereq == 2'b10) ? {sword, ~sword} : {~sword, sword};
        sb.push_back('{tag: tag, rdata: erdata, err: eerr, lat: elat, chk_rdata: rd});
        cpu_bus.cpu_rd    = rd;
        cpu_bus.cpu_wr    = wr;
        cpu_bus.cpu_size  = size;
        cpu_bus.cpu_sign  = sign;
        cpu_bus.cpu_addr  = addr;
        cpu_bus.cpu_wdata = wdata;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            @(posedge clk);
            #1;
            if (slv_bus.slv_req != 2'b00) begin
                rc++;
                if (rc == 1) begin
                    req_seen = slv_bus.slv_req;
                    check({tag, ":we"}, 32'(slv_bus.slv_we), 32'(wr));
                    check({tag, ":addr"}, 32'(slv_bus.slv_addr), 32'(eaddr));
                    check({tag, ":be"}, 32'(slv_bus.slv_be), 32'(ebe));
                    if (wr) check({tag, ":wdata"}, slv_bus.slv_wdata & mask, ewdata & mask);
                end
                slv_bus.slv_ack = (rc == dly + 1) ? slv_bus.slv_req : ~slv_bus.slv_req;
            end else begin
                slv_bus.slv_ack = 2'b00;
            end
            if (cpu_bus.cpu_ready) begin
                lat       = k;
                obs_rdata = cpu_bus.cpu_rdata;
                obs_err   = cpu_bus.cpu_err;
            end
        end
        cpu_bus.cpu_rd  = 1'b0;
        cpu_bus.cpu_wr  = 1'b0;
        slv_bus.slv_ack = 2'b00;
        check({tag, ":req"}, 32'(req_seen), 32'(ereq));
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s:scoreboard observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            check({e.tag, ":lat"}, 32'(lat), 32'(e.lat));
            check({e.tag, ":err"}, 32'(obs_err), 32'(e.err));
            if (e.chk_rdata) check({e.tag, ":rdata"}, obs_rdata, e.rdata);
        end
        @(posedge clk);
        #1;
        check({tag, ":pulse"}, 32'(cpu_bus.cpu_ready), 32'h0);
    endtask

    initial begin
        int pulses;
        cpu_bus.cpu_rd    = 1'b0;
        cpu_bus.cpu_wr    = 1'b0;
        cpu_bus.cpu_size  = SZ_WORD;
        cpu_bus.cpu_sign  = 1'b0;
        cpu_bus.cpu_addr  = 32'h0;
        cpu_bus.cpu_wdata = 32'h0;
        slv_bus.slv_rdata = '0;
        slv_bus.slv_ack   = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        check("rst:ready", 32'(cpu_bus.cpu_ready), 32'h0);
        check("rst:err", 32'(cpu_bus.cpu_err), 32'h0);
        check("rst:rdata", cpu_bus.cpu_rdata, 32'h0);
        check("rst:req", 32'(slv_bus.slv_req), 32'h0);
        check("rst:we", 32'(slv_bus.slv_we), 32'h0);
        check("rst:addr", 32'(slv_bus.slv_addr), 32'h0);
        check("rst:wdata", slv_bus.slv_wdata, 32'h0);
        check("rst:be", 32'(slv_bus.slv_be), 32'h0);
`ifdef DBUS_SEG_EN
        check("rst:seg", seg_val, 32'h0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        //      tag        rd wr size     sg addr          wdata         dly sword          req    addr     be    ewdata        erdata        err lat
        access("sw_word",  0, 1, SZ_WORD, 0, 32'h1001_0008, 32'hCAFE_BABE, 0, 32'h0,        2'b01, 16'h0008, 4'hF, 32'hCAFE_BABE, 32'h0,        0, 2);
        access("lb_sgn",   1, 0, SZ_BYTE, 1, 32'h1002_0003, 32'h0,         0, 32'h80FF_1234, 2'b10, 16'h0000, 4'h8, 32'h0,        32'hFFFF_FF80, 0, 2);
        access("lb_uns",   1, 0, SZ_BYTE, 0, 32'h1002_0003, 32'h0,         0, 32'h80FF_1234, 2'b10, 16'h0000, 4'h8, 32'h0,        32'h0000_0080, 0, 2);
        access("sh_hi",    0, 1, SZ_HALF, 0, 32'h1001_0002, 32'h0000_BEEF, 0, 32'h0,        2'b01, 16'h0000, 4'hC, 32'hBEEF_0000, 32'h0,        0, 2);
        access("lh_mis",   1, 0, SZ_HALF, 0, 32'h1001_0001, 32'h0,         0, 32'h1111_2222, 2'b00, 16'h0000, 4'h0, 32'h0,        32'h0,        1, 1);
        access("lw_wait3", 1, 0, SZ_WORD, 0, 32'h1001_0004, 32'h0,         3, 32'h1357_9BDF, 2'b01, 16'h0004, 4'hF, 32'h0,        32'h1357_9BDF, 0, 5);
        access("lw_tmo",   1, 0, SZ_WORD, 0, 32'h1002_0010, 32'h0,        -1, 32'h5555_AAAA, 2'b10, 16'h0010, 4'hF, 32'h0,        32'h0,        1, TIMEOUT + 2);
        access("miss",     1, 0, SZ_WORD, 0, 32'h0000_1000, 32'h0,         0, 32'h7777_7777, 2'b00, 16'h0000, 4'h0, 32'h0,        32'h0,        1, 1);
        access("sz11",     1, 0, 2'b11,   0, 32'h1001_0000, 32'h0,         0, 32'h7777_7777, 2'b00, 16'h0000, 4'h0, 32'h0,        32'h0,        1, 1);
        access("rdwr",     1, 1, SZ_WORD, 0, 32'h1001_0000, 32'h0,         0, 32'h7777_7777, 2'b00, 16'h0000, 4'h0, 32'h0,        32'h0,        1, 1);
        access("lw_mis",   1, 0, SZ_WORD, 0, 32'h1001_0002, 32'h0,         0, 32'h7777_7777, 2'b00, 16'h0000, 4'h0, 32'h0,        32'h0,        1, 1);
        access("lh_sgn",   1, 0, SZ_HALF, 1, 32'h1001_0002, 32'h0,         0, 32'h8001_7FFF, 2'b01, 16'h0000, 4'hC, 32'h0,        32'hFFFF_8001, 0, 2);
        access("lh_uns",   1, 0, SZ_HALF, 0, 32'h1002_0000, 32'h0,         1, 32'h1234_ABCD, 2'b10, 16'h0000, 4'h3, 32'h0,        32'h0000_ABCD, 0, 3);
        access("lb_pos",   1, 0, SZ_BYTE, 1, 32'h1001_0001, 32'h0,         0, 32'h0000_7F00, 2'b01, 16'h0000, 4'h2, 32'h0,        32'h0000_007F, 0, 2);
        access("sb_l1",    0, 1, SZ_BYTE, 0, 32'h1002_0001, 32'h1234_565A, 0, 32'h0,        2'b10, 16'h0000, 4'h2, 32'h0000_5A00, 32'h0,        0, 2);
        access("lw_top",   1, 0, SZ_WORD, 1, 32'h1001_FFFC, 32'h0,         0, 32'hDEAD_BEEF, 2'b01, 16'hFFFC, 4'hF, 32'h0,        32'hDEAD_BEEF, 0, 2);
`ifdef DBUS_SEG_EN
        access("seg_sw",   0, 1, SZ_WORD, 0, 32'h1003_0000, 32'h1234_5678, 0, 32'h0,        2'b00, 16'h0000, 4'h0, 32'h0,        32'h0,        0, 1);
        check("seg_sw:val", seg_val, 32'h1234_5678);
        access("seg_lw",   1, 0, SZ_WORD, 0, 32'h1003_0000, 32'h0,         0, 32'h0,        2'b00, 16'h0000, 4'h0, 32'h0,        32'h1234_5678, 0, 1);
        access("seg_sb",   0, 1, SZ_BYTE, 0, 32'h1003_0000, 32'h0000_00AA, 0, 32'h0,        2'b00, 16'h0000, 4'h0, 32'h0,        32'h0,        1, 1);
        check("seg_sb:val", seg_val, 32'h1234_5678);
`else
        access("seg_miss", 1, 0, SZ_WORD, 0, 32'h1003_0000, 32'h0,         0, 32'h0,        2'b00, 16'h0000, 4'h0, 32'h0,        32'h0,        1, 1);
`endif

        // Abandon a transaction with reset while the slave stalls.
        slv_bus.slv_ack   = 2'b00;
        cpu_bus.cpu_rd    = 1'b1;
        cpu_bus.cpu_size  = SZ_WORD;
        cpu_bus.cpu_addr  = 32'h1001_0010;
        repeat (2) @(posedge clk);
        #1;
        check("rstreq:pre", 32'(slv_bus.slv_req), 32'h1);
        rst = 1'b1;
        #1;
        check("rstreq:req", 32'(slv_bus.slv_req), 32'h0);
        check("rstreq:ready", 32'(cpu_bus.cpu_ready), 32'h0);
        cpu_bus.cpu_rd = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        pulses = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (cpu_bus.cpu_ready || slv_bus.slv_req != 2'b00) pulses++;
        end
        check("rstreq:quiet", 32'(pulses), 32'h0);

        access("post_rst", 1, 0, SZ_WORD, 0, 32'h1002_0008, 32'h0,         0, 32'h0BAD_F00D, 2'b10, 16'h0008, 4'hF, 32'h0,        32'h0BAD_F00D, 0, 2);

        check("sb:empty", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
